// File: rtl/lifo_stack.sv
// -----------------------------------------------------------------------------
// lifo_stack
//   Single-clock LIFO stack. The current top-of-stack lives in its own register,
//   so it is visible with zero read latency. The entries below it live in an
//   array. A pop refills the top register from array slot count-2 in the same
//   cycle, so there is never a bubble and never a busy state.
//
// Parameters
//   DEPTH : log2 of capacity (capacity = 2**DEPTH entries)
//   WIDTH : data bits per entry
//
// Ports
//   clk   in   clock, all state changes on the rising edge
//   rst   in   synchronous active-high reset
//   push  in   push wd this cycle
//   pop   in   pop the top entry this cycle (push+pop replaces the top entry)
//   wd    in   WIDTH  data to push
//   top   out  WIDTH  current top-of-stack (registered; 0 when empty)
//   count out  DEPTH+1 occupancy, 0..2**DEPTH
//   empty out  high when count==0
//   full  out  high when count==2**DEPTH
//   err   out  sticky overflow/underflow flag
//
// Build option
//   LIFO_STACK_ERR_EN : when defined, err is set on any overflow or underflow
//                       and held until rst. When undefined, err is tied to 0.
//                       Illegal operations are ignored in both builds.
// -----------------------------------------------------------------------------
module lifo_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] top,
    output logic [DEPTH:0]   count,
    output logic             empty,
    output logic             full,
    output logic             err
);

    // Address width stays at least 1 so that DEPTH=0 still elaborates.
    localparam int             AW      = (DEPTH > 0) ? DEPTH : 1;
    localparam int             CAP_INT = 1 << DEPTH;
    localparam logic [DEPTH:0] CAP     = CAP_INT[DEPTH:0];

    // One-hot-ish encoding: bit 0 means empty and bit 1 means full.
    // Both flags therefore come straight from state register bits.
    typedef enum logic [1:0] {
        S_PARTIAL = 2'b00,
        S_EMPTY   = 2'b01,
        S_FULL    = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [DEPTH:0]   r_count;
    logic [DEPTH:0]   w_count_next;
    logic [WIDTH-1:0] r_top;
    logic [WIDTH-1:0] w_top_next;

    // Entries below the top register. This array is deliberately not reset.
    logic [WIDTH-1:0] r_mem [0:CAP_INT-1];

    logic             w_push_only;
    logic             w_pop_only;
    logic             w_replace;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    logic [AW-1:0]    w_rd_addr;
    logic [WIDTH-1:0] w_below;

    assign w_push_only = push & ~pop & (r_state != S_FULL);
    assign w_pop_only  = pop & ~push & (r_state != S_EMPTY);
    assign w_replace   = push & pop & (r_state != S_EMPTY);

    // On a push, the old top moves into slot count-1.
    // The entry just below the top always sits in slot count-2.
    assign w_wr_addr = AW'(r_count - (DEPTH+1)'(1));
    assign w_rd_addr = AW'(r_count - (DEPTH+1)'(2));
    assign w_below   = r_mem[w_rd_addr];

    // Next-state and datapath decode.
    always_comb begin
        w_count_next = r_count;
        w_top_next   = r_top;
        w_wr_en      = 1'b0;
        if (w_push_only) begin
            w_count_next = r_count + (DEPTH+1)'(1);
            w_top_next   = wd;
            // Nothing is spilled into the array when the stack was empty.
            w_wr_en      = (r_state != S_EMPTY);
        end else if (w_pop_only) begin
            w_count_next = r_count - (DEPTH+1)'(1);
            w_top_next   = (r_count > (DEPTH+1)'(1)) ? w_below : '0;
        end else if (w_replace) begin
            w_top_next   = wd;
        end

        if (w_count_next == '0) begin
            w_state_next = S_EMPTY;
        end else if (w_count_next == CAP) begin
            w_state_next = S_FULL;
        end else begin
            w_state_next = S_PARTIAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_count <= '0;
            r_top   <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_top   <= w_top_next;
        end
    end

    // The old top only moves into the array on a push-only cycle.
    // A reset in the same cycle wins, so writes are gated by ~rst.
    always_ff @(posedge clk) begin
        if (w_wr_en && !rst) begin
            r_mem[w_wr_addr] <= r_top;
        end
    end

`ifdef LIFO_STACK_ERR_EN
    logic w_overflow;
    logic w_underflow;
    logic r_err;

    assign w_overflow  = push & ~pop & (r_state == S_FULL);
    assign w_underflow = pop & (r_state == S_EMPTY);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_overflow || w_underflow) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign top   = r_top;
    assign count = r_count;
    assign empty = r_state[0];
    assign full  = r_state[1];

endmodule

// File: tb/tb_lifo_stack.sv
// -----------------------------------------------------------------------------
// tb_lifo_stack
//   Self-checking bench for lifo_stack (DEPTH=2, WIDTH=16).
//   Stimulus comes from three sources:
//     - a vector table,
//     - a fill/overflow/drain sequence,
//     - a random phase checked against a queue-based stack model.
//   Each driven cycle pushes its expected outputs onto a scoreboard queue.
//   The entry is popped and compared just after the following clock edge.
// -----------------------------------------------------------------------------
module tb_lifo_stack;

    localparam int DEPTH = 2;
    localparam int WIDTH = 16;
    localparam int CAP   = 1 << DEPTH;
`ifdef LIFO_STACK_ERR_EN
    localparam logic E = 1'b1;
`else
    localparam logic E = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] wd = '0;
    logic [WIDTH-1:0] top;
    logic [DEPTH:0]   count;
    logic             empty;
    logic             full;
    logic             err;

    lifo_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wd    (wd),
        .top   (top),
        .count (count),
        .empty (empty),
        .full  (full),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             push;
        logic             pop;
        logic [WIDTH-1:0] wd;
        logic [WIDTH-1:0] e_top;
        logic [DEPTH:0]   e_count;
        logic             e_empty;
        logic             e_full;
        logic             e_err;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state for the random phase.
    logic [WIDTH-1:0] mdl[$];
    logic             mdl_err = 1'b0;

    function automatic vec_t mk(input logic r, input logic pu, input logic po,
                                input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] t,
                                input int c, input logic em, input logic fu,
                                input logic er);
        vec_t v;
        v.rst = r; v.push = pu; v.pop = po; v.wd = d;
        v.e_top = t; v.e_count = c[DEPTH:0]; v.e_empty = em; v.e_full = fu; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string name, input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
        end
    endtask

    // Drive one cycle and queue its expectation.
    // Then pop the expectation and compare it with the DUT after the edge.
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        rst = v.rst; push = v.push; pop = v.pop; wd = v.wd;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("top",   tag, 32'(top),   32'(e.e_top));
        chk("count", tag, 32'(count), 32'(e.e_count));
        chk("empty", tag, 32'(empty), 32'(e.e_empty));
        chk("full",  tag, 32'(full),  32'(e.e_full));
        chk("err",   tag, 32'(err),   32'(e.e_err));
        $display("[%0t] %s rst=%0b push=%0b pop=%0b wd=%04h -> top=%04h count=%0d empty=%0b full=%0b err=%0b",
                 $time, tag, v.rst, v.push, v.pop, v.wd, top, count, empty, full, err);
    endtask

    // Build the expected record from the behavioural stack model.
    function automatic vec_t model_step(input logic r, input logic pu, input logic po,
                                        input logic [WIDTH-1:0] d);
        vec_t v;
        if (r) begin
            mdl.delete();
            mdl_err = 1'b0;
        end else if (pu && po) begin
            if (mdl.size() == 0) mdl_err = E;
            else mdl[mdl.size()-1] = d;
        end else if (pu) begin
            if (mdl.size() == CAP) mdl_err = E;
            else mdl.push_back(d);
        end else if (po) begin
            if (mdl.size() == 0) mdl_err = E;
            else void'(mdl.pop_back());
        end
        v = mk(r, pu, po, d, (mdl.size() > 0) ? mdl[mdl.size()-1] : '0, mdl.size(),
               mdl.size() == 0, mdl.size() == CAP, mdl_err);
        return v;
    endfunction

    initial begin
        // rst push pop wd      top      cnt empty full err
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0));  // reset state
        vecs.push_back(mk(0, 1, 0, 16'h0011, 16'h0011, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0022, 16'h0022, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0033, 16'h0033, 3, 0, 0, 0));  // three pushes
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0022, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0011, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0));  // drained
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, E));  // underflow
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0011, 16'h0011, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0022, 16'h0022, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 16'h00AA, 16'h00AA, 2, 0, 0, 0));  // replace top
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0011, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0022, 16'h0022, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0033, 16'h0033, 3, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0044, 16'h0044, 4, 0, 1, 0));  // full
        vecs.push_back(mk(0, 1, 0, 16'hBEEF, 16'h0044, 4, 0, 1, E));  // overflow
        vecs.push_back(mk(0, 1, 1, 16'h0077, 16'h0077, 4, 0, 1, E));  // replace while full
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0033, 3, 0, 0, E));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0033, 3, 0, 0, E));  // idle
        vecs.push_back(mk(1, 1, 0, 16'h0099, 16'h0000, 0, 1, 0, 0));  // rst beats push
        vecs.push_back(mk(0, 1, 0, 16'h0055, 16'h0055, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 16'h0066, 16'h0000, 0, 1, 0, E));  // push+pop on empty
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0));

        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // Fill to capacity, attempt overflow, then drain in LIFO order.
        for (int i = 0; i < CAP; i++)
            step(mk(0, 1, 0, 16'hA000 + 16'(i), 16'hA000 + 16'(i), i + 1, 0, i + 1 == CAP, 0),
                 $sformatf("fill%0d", i));
        for (int i = 0; i < 3; i++)
            step(mk(0, 1, 0, 16'hDEAD, 16'hA000 + 16'(CAP - 1), CAP, 0, 1, E),
                 $sformatf("ovf%0d", i));
        for (int i = CAP - 1; i >= 0; i--)
            step(mk(0, 0, 1, 16'h0000, (i > 0) ? 16'hA000 + 16'(i - 1) : 16'h0000, i,
                    i == 0, 0, E), $sformatf("drain%0d", i));

        // Random traffic checked against the behavioural model.
        void'(model_step(1, 0, 0, '0));
        step(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0), "rnd_rst");
        for (int i = 0; i < 300; i++) begin
            logic r, pu, po;
            logic [WIDTH-1:0] d;
            r  = ($urandom_range(0, 40) == 0);
            pu = $urandom_range(0, 1) == 1;
            po = $urandom_range(0, 2) == 0;
            d  = 16'($urandom);
            step(model_step(r, pu, po, d), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lifo_stack.md
LIFO_STACK -- requirements
Module: lifo_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 4: log2 of entry count, so capacity is 2**DEPTH.
REQ-002 SHALL have parameter WIDTH, default 16: data bits per entry.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port push, input, 1 bit: push wd this cycle.
REQ-006 SHALL have port pop, input, 1 bit: pop the top entry this cycle.
REQ-007 SHALL have port wd, input, WIDTH bits: data to push.
REQ-008 SHALL have port top, output, WIDTH bits: current top-of-stack, registered.
REQ-009 SHALL have port count, output, DEPTH+1 bits: current occupancy, 0..2**DEPTH.
REQ-010 SHALL have port empty, output, 1 bit: high when count==0.
REQ-011 SHALL have port full, output, 1 bit: high when count==2**DEPTH.
REQ-012 SHALL have port err, output, 1 bit: sticky illegal-operation flag (see Configuration).

Function
REQ-013 SHALL hold state EMPTY, PARTIAL or FULL, with empty/full decoded from state and both driven from registers.
REQ-014 SHALL on push only, when not FULL: store wd, increment count, and show wd on top the next cycle.
REQ-015 SHALL on pop only, when not EMPTY: decrement count; the next cycle top SHALL show the entry below, or 0 when the stack goes empty.
REQ-016 SHALL on push and pop together, when not EMPTY: replace the top entry with wd, leave count unchanged, and show wd on top the next cycle, including when FULL.
REQ-017 SHALL ignore push when FULL without pop (overflow): no state change, stored data intact.
REQ-018 SHALL ignore pop, or push with pop, when EMPTY (underflow): no state change.
REQ-019 SHALL move EMPTY->PARTIAL on push, PARTIAL->FULL when count reaches 2**DEPTH, FULL->PARTIAL on pop, and PARTIAL->EMPTY when count reaches 0; with DEPTH=0, EMPTY<->FULL directly.
REQ-020 SHALL present top with zero-cycle read latency from its register; no operation takes more than one cycle and there is no busy state.
REQ-021 SHALL keep the top entry in the top register and entries below it in a 2**DEPTH x WIDTH array, with the array read address being count-2 so top refills without a bubble.
REQ-022 SHALL treat count as DEPTH+1 bits so a full stack does not wrap the pointer.

Reset
REQ-023 SHALL when rst is high at a clock edge set count=0, state=EMPTY, top=0 and err=0, overriding push/pop in that cycle.
REQ-024 SHALL not clear array contents on reset; they SHALL be unobservable until pushed again.
REQ-025 SHALL on reset asserted mid-sequence abandon the stack contents, with the first push after reset returning count=1.

Configuration
REQ-026 SHALL use macro LIFO_STACK_ERR_EN to compile the error logic in or out.
REQ-027 SHALL when LIFO_STACK_ERR_EN is defined set err on any overflow or underflow event and hold it until rst.
REQ-028 SHALL when LIFO_STACK_ERR_EN is undefined tie err to 0, with overflow and underflow still ignored per REQ-017/018.

Verification
REQ-029 SHALL cover: reset, then push 0x0011, 0x0022, 0x0033 on consecutive cycles -> top 0x0033, count 3, empty 0, full 0.
REQ-030 SHALL cover: with DEPTH=2, push 4 values then push 0xBEEF -> full 1, count 4, top unchanged, and err 1 only with LIFO_STACK_ERR_EN.
REQ-031 SHALL cover: from count 3 with top 0x0033, pop on three consecutive cycles -> top 0x0022, then 0x0011, then 0, ending with empty 1.
REQ-032 SHALL cover: pop when empty -> count stays 0, top 0, err 1 with the macro and 0 without.
REQ-033 SHALL cover: from count 2 with top 0x0022, push+pop with wd=0x00AA -> count 2, top 0x00AA; a following pop SHALL give top 0x0011.
REQ-034 SHALL cover: rst asserted with push high at count 3 -> count 0, empty 1, err 0; then push 0x0055 -> count 1, top 0x0055.
